// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the addi/lw/sw multi-cycle sequencer.
// Holds the FSM state encoding, the opcode fields and the instruction classifier.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        CLS_ILLEGAL = 2'd0,
        CLS_ADDI    = 2'd1,
        CLS_LW      = 2'd2,
        CLS_SW      = 2'd3
    } instr_cls_e;

    localparam logic [4:0]  OP_OPIMM = 5'b00100;
    localparam logic [4:0]  OP_LOAD  = 5'b00000;
    localparam logic [4:0]  OP_STORE = 5'b01000;
    localparam logic [2:0]  F3_ADDI  = 3'b000;
    localparam logic [2:0]  F3_W     = 3'b010;
    localparam logic [31:0] PC_STEP  = 32'd4;

    function automatic instr_cls_e classify(input logic [4:0] opcode, input logic [2:0] funct3);
        instr_cls_e cls;
        cls = CLS_ILLEGAL;
        if ((opcode == OP_OPIMM) && (funct3 == F3_ADDI)) begin
            cls = CLS_ADDI;
        end else if ((opcode == OP_LOAD) && (funct3 == F3_W)) begin
            cls = CLS_LW;
        end else if ((opcode == OP_STORE) && (funct3 == F3_W)) begin
            cls = CLS_SW;
        end else begin
            cls = CLS_ILLEGAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the sequencer (master)
// and the memory side (slave).
interface instr_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );

endinterface

// File: rtl/instr_sequencer_handshake_timer.sv
// Counts cycles a request waits without ack; flags the final allowed cycle so
// the sequencer can abort on the following edge unless ack arrives in it.
module instr_sequencer_handshake_timer #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic wait_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int unsigned    CW   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire_o = wait_i && !ack_i && (cnt_q == LAST);

    // Idle or acknowledged handshakes clear the count, so every new wait starts at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (!wait_i || ack_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Wait counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM for the addi/lw/sw datapath: fetch, decode, execute,
// memory and write-back phases, PC and retired-count ownership, halt and errors.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    instr_sequencer_if.master        bus,
    output logic [31:0]              ir,
    output logic                     decode_en,
    output logic                     alu_en,
    output logic                     rf_we,
    output logic [31:0]              pc,
    output logic [31:0]              instret,
    output logic [2:0]               state,
    output logic                     halted,
    output logic                     err_illegal,
    output logic                     err_timeout
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] instret_q, instret_d;
    logic        err_illegal_q, err_illegal_d;
    logic        err_timeout_q, err_timeout_d;
    logic        imem_req_q, dmem_req_q, dmem_we_q;
    logic        decode_en_q, alu_en_q, rf_we_q, halted_q;

    instr_cls_e  cls_s;
    logic        imem_take_s, dmem_take_s;
    logic        wait_s, ack_s, expire_s;

    assign cls_s       = classify(ir_q[6:2], ir_q[14:12]);
    assign imem_take_s = imem_req_q && bus.imem_ack;
    assign dmem_take_s = dmem_req_q && bus.dmem_ack;
    assign wait_s      = imem_req_q || dmem_req_q;
    assign ack_s       = imem_take_s || dmem_take_s;

    instr_sequencer_handshake_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .wait_i  (wait_s),
        .ack_i   (ack_s),
        .expire_o(expire_s)
    );

    // Next-state, PC, instruction register and sticky error logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        instret_d     = instret_q;
        err_illegal_d = err_illegal_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
                else       state_d = S_IDLE;
            end
            S_FETCH: begin
                if (imem_take_s) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_DECODE;
                end else if (expire_s) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (cls_s == CLS_ILLEGAL) begin
                    err_illegal_d = 1'b1;
                    state_d       = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls_s == CLS_ADDI) state_d = S_WB;
                else                   state_d = S_MEM;
            end
            S_MEM: begin
                // Stores retire straight out of MEM; loads still need a write-back.
                if (dmem_take_s) begin
                    if (cls_s == CLS_SW) begin
                        pc_d      = pc_q + PC_STEP;
                        instret_d = instret_q + 32'd1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (expire_s) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_HALT;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                pc_d      = pc_q + PC_STEP;
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // State and registered Moore outputs; reset drops the requests without a clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= 32'h0000_0000;
            instret_q     <= 32'h0000_0000;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
            imem_req_q    <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            decode_en_q   <= 1'b0;
            alu_en_q      <= 1'b0;
            rf_we_q       <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            instret_q     <= instret_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
            imem_req_q    <= (state_d == S_FETCH);
            dmem_req_q    <= (state_d == S_MEM);
            dmem_we_q     <= (state_d == S_MEM) && (cls_s == CLS_SW);
            decode_en_q   <= (state_d == S_DECODE);
            alu_en_q      <= (state_d == S_EXEC);
            rf_we_q       <= (state_d == S_WB);
            halted_q      <= (state_d == S_HALT);
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_we_q;
    assign ir            = ir_q;
    assign decode_en     = decode_en_q;
    assign alu_en        = alu_en_q;
    assign rf_we         = rf_we_q;
    assign pc            = pc_q;
    assign instret       = instret_q;
    assign state         = state_q;
    assign halted        = halted_q;
    assign err_illegal   = err_illegal_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM that runs the single-issue datapath for the supported subset: addi, lw, sw.
- Each instruction is fetched from instruction memory over a req/ack handshake and held in an instruction register, which drives the decoder.
- The block then steps the decoder, ALU, data-memory and register-file write strobes through the required phases.
- It owns the PC, the retired-instruction counter and halt/error reporting.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ACK_TIMEOUT, 16: maximum cycles a req may wait for ack before a bus error is raised.

Ports:
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; leaves IDLE
- imem_req  output  1  instruction fetch request
- imem_addr  output  32  fetch address (= pc)
- imem_ack  input  1  fetch data valid
- imem_rdata  input  32  fetched instruction
- ir  output  32  instruction register, to decoder
- decode_en  output  1  decoder latch strobe
- alu_en  output  1  ALU/address-generate strobe
- dmem_req  output  1  data memory request
- dmem_we  output  1  1 = store, 0 = load; valid while dmem_req
- dmem_ack  input  1  data memory done
- rf_we  output  1  register-file write strobe
- pc  output  32  current PC
- instret  output  32  retired instruction count
- state  output  3  FSM state, debug
- halted  output  1  FSM in HALT
- err_illegal  output  1  sticky: unsupported instruction
- err_timeout  output  1  sticky: ack timeout

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, pc = RESET_PC, ir = 0, instret = 0.
  - All strobes and req outputs are 0; halted, err_illegal and err_timeout are 0.
- State encoding: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 6.
- IDLE: on start = 1, go to FETCH. start is ignored in every other state.
- FETCH:
  - imem_req = 1 and imem_addr = pc, both held stable until ack.
  - On a clock edge with imem_ack = 1: ir <= imem_rdata, go to DECODE. imem_req is 0 in the next cycle.
  - An ack in the same cycle req first rises is accepted.
- DECODE:
  - decode_en = 1 for exactly 1 cycle.
  - Classification uses ir[6:2] and ir[14:12]:
    - 00100/000 = addi
    - 00000/010 = lw
    - 01000/010 = sw
  - Any other encoding: set err_illegal, go to HALT. pc and instret are unchanged.
  - Supported instruction: go to EXEC.
- EXEC: alu_en = 1 for 1 cycle. Next state is WB for addi, MEM for lw and sw.
- MEM:
  - dmem_req = 1; dmem_we = 1 for sw, 0 for lw.
  - On dmem_ack: lw goes to WB; sw retires (pc += 4, instret += 1) and goes to FETCH.
- WB: rf_we = 1 for 1 cycle; retire (pc += 4, instret += 1); go to FETCH.
- Cycle counts with zero-wait ack:
  - addi: 4 cycles (FETCH, DECODE, EXEC, WB)
  - lw: 5 cycles (adds MEM)
  - sw: 4 cycles (FETCH, DECODE, EXEC, MEM)
- Strobes are Moore outputs decoded from state; only the req signals are held across waits.
- Timeout:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle req is high without ack.
  - When the count reaches ACK_TIMEOUT - 1 with no ack, the next edge sets err_timeout and goes to HALT, with req dropping.
  - An ack on that same edge wins: no error is raised.
- Arithmetic: pc wraps modulo 2^32; instret wraps modulo 2^32.
- An ack arriving while the matching req is 0 is ignored.
- HALT:
  - halted = 1, all strobes 0. HALT is terminal; only reset exits.
  - Error flags are sticky until reset.
- Reset mid-handshake: all req outputs drop immediately (asynchronously). Memories must tolerate an abandoned request.

Decomposition:
- Shared package holds:
  - state enum constants
  - opcode constants OP_OPIMM = 5'b00100, OP_LOAD = 5'b00000, OP_STORE = 5'b01000
  - funct3 constants F3_ADDI = 3'b000, F3_W = 3'b010
  - PC_STEP = 4
- Sub-module handshake_timer: wait counter plus timeout compare; one instance, shared by FETCH and MEM.

Test Plan:
- Reset then start; imem returns addi 0x00500093 with zero wait → states 1, 2, 3, 5, 1; rf_we pulses once; pc = 4; instret = 1.
- lw 0x0000A103 with imem ack delayed 3 cycles and dmem ack delayed 2 → imem_req held high 4 cycles with imem_addr constant; dmem_we = 0; rf_we one pulse; pc += 4.
- sw 0x0020A023 → dmem_req with dmem_we = 1; rf_we never asserted; retires on dmem_ack; instret += 1.
- Fetch returns 0x00000033 (R-type) → err_illegal = 1, halted = 1, state = 6; pc and instret unchanged; later start pulses ignored.
- ACK_TIMEOUT = 4 with imem_ack held 0 → err_timeout set after 4 req cycles; imem_req = 0 afterwards. Repeat with ack in the 4th cycle → no error.
- Assert reset while dmem_req = 1 → dmem_req falls without a clock edge; after release, pc = RESET_PC and state = IDLE.
